// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Latches the winner's operands, drives the ALU for one cycle and holds the result until it is taken.
module alu_share_arbiter #(
  parameter int XLEN    = 32,
  parameter bit RR_INIT = 1'b0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [3:0]      req0_op_i,
  input  logic [XLEN-1:0] req0_a_i,
  input  logic [XLEN-1:0] req0_b_i,
  input  logic [3:0]      req1_op_i,
  input  logic [XLEN-1:0] req1_a_i,
  input  logic [XLEN-1:0] req1_b_i,
  output logic [XLEN-1:0] alu_src_a_o,
  output logic [XLEN-1:0] alu_src_b_o,
  output logic [3:0]      alu_op_o,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  output logic            rsp_valid_o,
  input  logic            rsp_ready_i,
  output logic            rsp_id_o,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            rsp_zero_o,
  output logic            rsp_err_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  typedef struct packed {
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            id;
  } req_t;

  state_t state;
  req_t   req_q;
  logic   rr_ptr;
  logic   accept_en;
  logic   grant_id;
  logic   accept;

  // Reset gates the handshake so nothing is granted while the block is being cleared.
  always_comb begin
    accept_en = !rst_i && ((state == IDLE) || ((state == RESP) && rsp_ready_i));
    case (req_valid_i)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      default: grant_id = rr_ptr;
    endcase
    req_ready_o = 2'b00;
    if (accept_en && (|req_valid_i)) req_ready_o[grant_id] = 1'b1;
    accept = |req_ready_o;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= RR_INIT;
      req_q        <= '0;
      rsp_id_o     <= 1'b0;
      rsp_result_o <= '0;
      rsp_zero_o   <= 1'b0;
      rsp_err_o    <= 1'b0;
    end else if (accept) begin
      req_q.op <= grant_id ? req1_op_i : req0_op_i;
      req_q.a  <= grant_id ? req1_a_i  : req0_a_i;
      req_q.b  <= grant_id ? req1_b_i  : req0_b_i;
      req_q.id <= grant_id;
      rr_ptr   <= ~grant_id;
      state    <= EXEC;
    end else begin
      case (state)
        EXEC: begin
          rsp_id_o     <= req_q.id;
          rsp_result_o <= alu_result_i;
          rsp_zero_o   <= alu_zero_i;
          rsp_err_o    <= (req_q.op > 4'd9);
          state        <= RESP;
        end
        RESP:    if (rsp_ready_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_op_o    = req_q.op;
  assign alu_src_a_o = req_q.a;
  assign alu_src_b_o = req_q.b;
  assign rsp_valid_o = (state == RESP);
  assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a small reference ALU on the shared port.
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_op;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [31:0] rsp_result;
  int total = 0;
  int bad   = 0;

  alu_share_arbiter #(.XLEN(32), .RR_INIT(1'b0)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req0_op_i(req0_op), .req0_a_i(req0_a), .req0_b_i(req0_b),
    .req1_op_i(req1_op), .req1_a_i(req1_a), .req1_b_i(req1_b),
    .alu_src_a_o(alu_a), .alu_src_b_o(alu_b), .alu_op_o(alu_op),
    .alu_result_i(alu_res), .alu_zero_i(alu_zero),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_err_o(rsp_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return $unsigned($signed(a) >>> b[4:0]);
      4'd8: return {31'b0, $signed(a) < $signed(b)};
      4'd9: return {31'b0, a < b};
      default: return 32'h0;
    endcase
  endfunction

  assign alu_res  = ref_alu(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_res == 32'h0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
    tick();
    total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_state got=%b%b exp=00", rsp_valid, busy); end
    total++; if ({alu_op, alu_a, alu_b} !== 68'h0) begin bad++; $display("FAIL reset_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
    total++; if ({rsp_id, rsp_result, rsp_zero, rsp_err} !== 35'h0) begin bad++; $display("FAIL reset_rsp got=%b/%h/%b/%b exp=0", rsp_id, rsp_result, rsp_zero, rsp_err); end
    req_valid = 2'b00; rst = 1'b0;
    tick();
  endtask

  task automatic test_add;
    rsp_ready = 1'b1; req0_op = 4'd0; req0_a = 32'd5; req0_b = 32'd7; req_valid = 2'b01;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL add_ready got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00; #1;
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 2'b00) begin bad++; $display("FAIL add_exec got=%b%b%b exp=1000", busy, rsp_valid, req_ready); end
    total++; if (alu_a !== 32'd5 || alu_b !== 32'd7 || alu_op !== 4'd0) begin bad++; $display("FAIL add_alu got=%0d/%0d/%0d exp=5/7/0", alu_a, alu_b, alu_op); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_zero !== 1'b0 || rsp_id !== 1'b0 || rsp_err !== 1'b0)
      begin bad++; $display("FAIL add_rsp got=v%b r%0d z%b id%b e%b exp=v1 r12 z0 id0 e0", rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err); end
    tick();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL add_idle got=%b%b exp=00", rsp_valid, busy); end
  endtask

  task automatic test_round_robin;
    rst = 1'b1; tick(); rst = 1'b0;
    rsp_ready = 1'b1;
    req0_op = 4'd0; req0_a = 32'd1;  req0_b = 32'd1;
    req1_op = 4'd0; req1_a = 32'd10; req1_b = 32'd10;
    req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (req_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin bad++; $display("FAIL rr_grant%0d got=%b", i, req_ready); end
      tick(); tick();
      total++; if (rsp_valid !== 1'b1 || rsp_id !== ((i % 2 == 0) ? 1'b0 : 1'b1) || rsp_result !== ((i % 2 == 0) ? 32'd2 : 32'd20))
        begin bad++; $display("FAIL rr_rsp%0d got=v%b id%b r%0d", i, rsp_valid, rsp_id, rsp_result); end
    end
    req_valid = 2'b00;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rr_idle got=%b exp=0", busy); end
  endtask

  task automatic test_hold;
    rsp_ready = 1'b0; req1_op = 4'd1; req1_a = 32'd9; req1_b = 32'd9; req_valid = 2'b10;
    #1;
    total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL hold_grant got=%b exp=10", req_ready); end
    tick(); req_valid = 2'b11; tick();
    for (int i = 0; i < 5; i++) begin
      total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_id !== 1'b1 || req_ready !== 2'b00)
        begin bad++; $display("FAIL hold_c%0d got=v%b r%0d z%b id%b rdy%b", i, rsp_valid, rsp_result, rsp_zero, rsp_id, req_ready); end
      tick();
    end
    req_valid = 2'b00; rsp_ready = 1'b1;
    tick();
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_release got=%b%b exp=00", rsp_valid, busy); end
  endtask

  task automatic test_illegal;
    rsp_ready = 1'b1; req0_op = 4'b1100; req0_a = 32'd3; req0_b = 32'd4; req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    total++; if (alu_op !== 4'b1100) begin bad++; $display("FAIL ill_fwd got=%b exp=1100", alu_op); end
    tick();
    total++; if (rsp_valid !== 1'b1 || rsp_result !== 32'd0 || rsp_zero !== 1'b1 || rsp_err !== 1'b1)
      begin bad++; $display("FAIL ill_rsp got=v%b r%0d z%b e%b exp=v1 r0 z1 e1", rsp_valid, rsp_result, rsp_zero, rsp_err); end
    tick();
  endtask

  task automatic test_back_to_back;
    rsp_ready = 1'b1; req0_op = 4'd8; req0_a = 32'hFFFF_FFFF; req0_b = 32'd1; req_valid = 2'b01;
    tick();
    for (int c = 1; c <= 8; c++) begin
      total++; if (busy !== 1'b1 || rsp_valid !== (c % 2 == 0)) begin bad++; $display("FAIL b2b_c%0d got=busy%b v%b", c, busy, rsp_valid); end
      if (c % 2 == 0) begin
        total++; if (rsp_result !== 32'd1 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin bad++; $display("FAIL b2b_res%0d got=r%0d id%b e%b exp=r1 id0 e0", c, rsp_result, rsp_id, rsp_err); end
      end
      if (c == 8) req_valid = 2'b00;
      tick();
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b1; req0_op = 4'd0; req0_a = 32'd6; req0_b = 32'd6; req_valid = 2'b01;
    tick(); req_valid = 2'b00;
    rst = 1'b1;
    tick(); rst = 1'b0;
    total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mid_state got=%b%b exp=00", rsp_valid, busy); end
    total++; if ({alu_op, alu_a, alu_b} !== 68'h0) begin bad++; $display("FAIL mid_alu got=%h/%h/%h exp=0", alu_op, alu_a, alu_b); end
    tick();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_norsp got=%b exp=0", rsp_valid); end
    req1_op = 4'd0; req1_a = 32'd2; req1_b = 32'd3; req_valid = 2'b11;
    #1;
    total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL mid_rrinit got=%b exp=01", req_ready); end
    tick(); req_valid = 2'b00; tick();
    total++; if (rsp_id !== 1'b0 || rsp_result !== 32'd12) begin bad++; $display("FAIL mid_after got=id%b r%0d exp=id0 r12", rsp_id, rsp_result); end
    tick();
  endtask

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
    req0_op = 4'd0; req0_a = '0; req0_b = '0;
    req1_op = 4'd0; req1_a = '0; req1_b = '0;
    tick();
    test_reset();
    test_add();
    test_round_robin();
    test_hold();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
